// File: rtl/gc_pkg.sv
// gc_pkg: shared GameCube command-line types, command constants and bit waveforms.
package gc_pkg;
    typedef enum logic [1:0] {IDLE, DATA, STOP, GUARD} state_t;
    localparam logic [7:0]  GC_CMD_PROBE      = 8'h00;
    localparam logic [23:0] GC_CMD_POLL       = 24'h400302;
    localparam logic [7:0]  GC_WB_INIT_PREFIX = 8'h4E;
    // Indexed by quarter number: 1 = line pulled low in that quarter.
    localparam logic [3:0]  PAT_ZERO = 4'b0111;
    localparam logic [3:0]  PAT_ONE  = 4'b0001;
    localparam logic [3:0]  PAT_STOP = 4'b0001;
    localparam logic [3:0]  OE_STOP  = 4'b0011;
endpackage

// File: rtl/gc_quarter_timer.sv
// gc_quarter_timer: quarter-bit divider with a 2-bit quarter index and next-cycle lookahead.
module gc_quarter_timer #(
    parameter int CLKS_PER_QUARTER = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    output logic       end_o,
    output logic [1:0] q_o,
    output logic       end_nxt_o,
    output logic [1:0] q_nxt_o
);
    localparam int CW = $clog2(CLKS_PER_QUARTER);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_QUARTER - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    q_q;
    assign end_o     = !clr_i && cnt_q == LAST;
    assign cnt_d     = (clr_i || end_o) ? '0 : cnt_q + CW'(1);
    assign q_nxt_o   = clr_i ? 2'd0 : q_q + 2'(end_o);
    assign end_nxt_o = cnt_d == LAST;
    assign q_o       = q_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            q_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_nxt_o;
        end
    end
endmodule

// File: rtl/gc_cmd_tx.sv
// gc_cmd_tx: serialises a 1..MAX_BYTES command onto the GameCube data line with a stop bit.
// Outputs are flops loaded from next-state decode, so the pad sees no combinational logic.
module gc_cmd_tx #(
    parameter int CLKS_PER_QUARTER = 100,
    parameter int MAX_BYTES        = 3,
    parameter int GUARD_CYCLES     = 0,
    parameter int LEN_W            = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [8*MAX_BYTES-1:0] cmd_data,
    input  logic [LEN_W-1:0]       cmd_len,
    input  logic                   start,
    output logic                   busy,
    output logic                   tx_low,
    output logic                   tx_active,
    output logic                   done,
    output logic                   len_err
);
    import gc_pkg::*;
    localparam int W  = 8 * MAX_BYTES;
    localparam int BW = $clog2(W);
    localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;
    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [BW-1:0] bits_q, bits_d;
    logic [GW-1:0] g_q, g_d;
    logic          busy_q, tx_low_q, tx_active_q, done_q, len_err_q;
    logic          busy_d, tx_low_d, tx_active_d, done_d, len_err_d;
    logic          q_end, end_nxt, bit_end, legal, bit_val;
    logic [1:0]    q, q_nxt;

    gc_quarter_timer #(.CLKS_PER_QUARTER(CLKS_PER_QUARTER)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q != DATA && state_q != STOP),
        .end_o     (q_end),
        .q_o       (q),
        .end_nxt_o (end_nxt),
        .q_nxt_o   (q_nxt)
    );

    assign legal   = cmd_len != '0 && int'(cmd_len) <= MAX_BYTES;
    assign bit_end = q_end && q == 2'd3;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        bits_d    = bits_q;
        g_d       = '0;
        len_err_d = 1'b0;
        if (state_q == IDLE && start) begin
            if (legal) begin
                state_d = DATA;
                data_d  = cmd_data;
                bits_d  = BW'({cmd_len, 3'b000} - (LEN_W + 3)'(1));
            end else begin
                len_err_d = 1'b1;
            end
        end else if (state_q == DATA && bit_end) begin
            data_d = data_q << 1;
            if (bits_q == '0) state_d = STOP;
            else bits_d = bits_q - BW'(1);
        end else if (state_q == STOP && bit_end) begin
            state_d = GUARD_CYCLES > 0 ? GUARD : IDLE;
        end else if (state_q == GUARD) begin
            g_d = g_q + GW'(1);
            if (g_q == GW'(GUARD_CYCLES - 1)) state_d = IDLE;
        end
        bit_val     = data_d[W-1];
        tx_low_d    = state_d == DATA ? (bit_val ? PAT_ONE[q_nxt] : PAT_ZERO[q_nxt])
                                      : (state_d == STOP && PAT_STOP[q_nxt]);
        tx_active_d = state_d == DATA || (state_d == STOP && OE_STOP[q_nxt]);
        done_d      = state_d == STOP && q_nxt == 2'd3 && end_nxt;
        busy_d      = state_d != IDLE && !(done_d && GUARD_CYCLES == 0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            bits_q      <= '0;
            g_q         <= '0;
            busy_q      <= 1'b0;
            tx_low_q    <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            bits_q      <= bits_d;
            g_q         <= g_d;
            busy_q      <= busy_d;
            tx_low_q    <= tx_low_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
        end
    end

    assign busy      = busy_q;
    assign tx_low    = tx_low_q;
    assign tx_active = tx_active_q;
    assign done      = done_q;
    assign len_err   = len_err_q;
endmodule
